// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digits are latched once per frame so a frame never mixes old and new values.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  anode_out,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [31:0]   BLANK_LEN = 32'(BLANK_CYCLES);

    typedef enum logic {PARKED, SCANNING} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    idx_d;
    logic          load;
    logic [15:0]   shd_dig, shd_dig_d;
    logic [3:0]    shd_dp, shd_dp_d;
    logic [3:0]    hi_zero;
    logic [3:0]    cur_digit;
    logic          drive;
    logic [3:0]    anode_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = digit_idx;
        load    = 1'b0;
        if (!enable) begin
            state_d = PARKED;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else if (state == PARKED) begin
            // Leaving park always begins a fresh frame in slot 0.
            state_d = SCANNING;
            cnt_d   = '0;
            idx_d   = 2'd0;
            load    = 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt_d = '0;
            idx_d = digit_idx + 2'd1;
            load  = (digit_idx == 2'd3);
        end else begin
            cnt_d = cnt + CW'(1);
        end
    end

    // Outputs are computed from next-state values so they register on the same edge as cnt.
    always_comb begin
        shd_dig_d  = load ? digits  : shd_dig;
        shd_dp_d   = load ? dp_mask : shd_dp;
        hi_zero[3] = (shd_dig_d[15:12] == 4'd0) && !shd_dp_d[3];
        hi_zero[2] = hi_zero[3] && (shd_dig_d[11:8] == 4'd0) && !shd_dp_d[2];
        hi_zero[1] = hi_zero[2] && (shd_dig_d[7:4] == 4'd0) && !shd_dp_d[1];
        hi_zero[0] = 1'b0;
        cur_digit  = shd_dig_d[4*idx_d +: 4];
        drive      = enable && (32'(cnt_d) >= BLANK_LEN)
                     && !((LZ_SUPPRESS != 0) && hi_zero[idx_d]);
        anode_d    = 4'b1111;
        seg_d      = 7'b1111111;
        dp_d       = 1'b1;
        if (drive) begin
            anode_d = ~(4'b0001 << idx_d);
            seg_d   = decode(cur_digit);
            dp_d    = ~shd_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PARKED;
            cnt        <= '0;
            digit_idx  <= 2'd0;
            shd_dig    <= 16'd0;
            shd_dp     <= 4'd0;
            anode_out  <= 4'b1111;
            seg_out    <= 7'b1111111;
            dp_out     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            digit_idx  <= idx_d;
            shd_dig    <= shd_dig_d;
            shd_dp     <= shd_dp_d;
            anode_out  <= anode_d;
            seg_out    <= seg_d;
            dp_out     <= dp_d;
            frame_tick <= load;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: per-cycle expected outputs queued per frame,
// popped and compared one cycle at a time.
module tb_seven_seg_scanner;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  anode_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    // Packed observation: {frame_tick, digit_idx, anode_out, seg_out, dp_out}
    logic [14:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [14:0] IDLE = {1'b0, 2'd0, 4'b1111, 7'b1111111, 1'b1};

    seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp_mask(dp_mask),
        .anode_out(anode_out), .seg_out(seg_out), .dp_out(dp_out),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1000000;  4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;  4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;  4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;  4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;  4'd9: seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    function automatic logic [14:0] observed();
        return {frame_tick, digit_idx, anode_out, seg_out, dp_out};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (tick,idx,anode,seg,dp)", tag, got, want);
        end
    endtask

    // Queue one full frame (4 slots of DIV cycles) as the display should show it.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp);
        for (int k = 0; k < 4; k++) begin
            logic        supp;
            logic [3:0]  an;
            supp = 1'b0;
            if (k > 0) begin
                supp = 1'b1;
                for (int j = k; j < 4; j++)
                    if (d[4*j +: 4] != 4'd0 || dp[j]) supp = 1'b0;
            end
            an = 4'b1111;
            an[k] = 1'b0;
            for (int c = 0; c < DIV; c++) begin
                logic tick;
                tick = (k == 0 && c == 0);
                if (c < BLANK || supp)
                    exp_q.push_back({tick, 2'(k), 4'b1111, 7'b1111111, 1'b1});
                else
                    exp_q.push_back({tick, 2'(k), an, seg_of(d[4*k +: 4]), ~dp[k]});
            end
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: scoreboard empty, observed %h expected entry", tag, observed());
            end else begin
                check(tag, observed(), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        digits  = 16'h0000;
        dp_mask = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset", observed(), IDLE);

        // Basic scan, first edge after release performs the frame load.
        rst_n  = 1'b1;
        enable = 1'b1;
        digits = 16'h1234;
        push_frame(16'h1234, 4'b0000);
        run("scan_1234", 32);

        // Mid-frame change must not tear the current frame.
        push_frame(16'h1234, 4'b0000);
        run("tearfree_pre", 11);
        digits = 16'h5678;
        run("tearfree_old", 21);
        push_frame(16'h5678, 4'b0000);
        run("tearfree_new", 32);

        digits = 16'h0050;
        push_frame(16'h0050, 4'b0000);
        run("lz_plain", 32);

        dp_mask = 4'b0100;
        push_frame(16'h0050, 4'b0100);
        run("lz_dp", 32);

        digits  = 16'h000C;
        dp_mask = 4'b0000;
        push_frame(16'h000C, 4'b0000);
        run("invalid_bcd", 32);

        // Drop enable during slot 2, park, then restart.
        digits = 16'h1234;
        push_frame(16'h1234, 4'b0000);
        run("pre_disable", 19);
        enable = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(IDLE);
        run("parked", 5);
        enable = 1'b1;
        push_frame(16'h1234, 4'b0000);
        run("reenable", 32);

        // Asynchronous reset in the middle of a driving slot.
        push_frame(16'h1234, 4'b0000);
        run("pre_reset", 12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", observed(), IDLE);
        @(posedge clk);
        #1;
        check("reset_hold", observed(), IDLE);
        rst_n = 1'b1;
        exp_q.delete();
        push_frame(16'h1234, 4'b0000);
        run("post_reset", 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Time-multiplexed driver for the stopwatch's 4-digit common-anode 7-segment display. It takes four BCD digits and a decimal-point mask, and cycles through the digits one at a time. For each digit it produces an active-low anode select plus the matching active-low segment and dp pattern. Its anode_out is the pattern consumed by blinking_display's anode input, and it includes a per-slot blanking interval to suppress ghosting. Digits are latched once per frame, so a frame never mixes old and new values.

Parameters:
REFRESH_DIV, 1000, clock cycles per digit slot; must be >= BLANK_CYCLES+1.
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off; must be >= 0.
LZ_SUPPRESS, 1, when 1, leading zeros are blanked.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  scan enable; 0 blanks the display and parks the scanner
digits  input  16  BCD digits; digit k = digits[4k+3:4k], digit 0 is rightmost
dp_mask  input  4  bit k = 1 lights the decimal point of digit k
anode_out  output  4  active-low one-hot anode select; 4'b1111 = all off
seg_out  output  7  active-low segments {g,f,e,d,c,b,a}
dp_out  output  1  active-low decimal point
digit_idx  output  2  index of the current slot
frame_tick  output  1  one-cycle pulse when a frame starts and the shadow registers load

Behaviour:
- Reset (async, rst_n=0):
  - anode_out=4'b1111, seg_out=7'b1111111, dp_out=1, digit_idx=0, frame_tick=0.
  - Slot counter=0, shadow digits=0, shadow dp=0.
- State: slot counter cnt counts 0..REFRESH_DIV-1; digit_idx counts 0..3. All outputs are registered and update on the same edge as cnt.
- Slot timing:
  - At cnt==REFRESH_DIV-1, cnt goes to 0 and digit_idx increments, wrapping 3->0.
  - Within a slot, cycles with cnt<BLANK_CYCLES are BLANK: anode_out=1111, seg_out=1111111, dp_out=1.
  - Cycles with cnt>=BLANK_CYCLES are DRIVE: anode_out has bit digit_idx low and the others high; seg_out and dp_out come from the shadow digit.
- Frame load: on the edge that enters cnt=0 with digit_idx=0, the shadow registers take digits and dp_mask, and frame_tick=1 for that one cycle. Changes to digits or dp_mask mid-frame take effect at the next frame.
- Segment decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes A-F show dash, 0111111.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit k (k=3,2,1) is suppressed when shadow digits k..3 are all 0 and shadow dp bits k..3 are all 0.
  - A suppressed slot stays fully blank (anode_out=1111) for its whole duration.
  - Digit 0 is never suppressed.
- dp_out = ~shadow_dp[digit_idx] during DRIVE.
- enable=0 (sampled synchronously): next edge gives cnt=0, digit_idx=0, blank outputs, frame_tick=0, and the scanner holds there.
- enable 0->1: on the first enabled edge the scanner performs a frame load (frame_tick=1) and starts slot 0 in BLANK.
- Reset asserted mid-slot: outputs go to their reset values immediately, without waiting for clk. After release, the first enabled edge performs a frame load.
- Frame period is 4*REFRESH_DIV cycles, and frame_tick is periodic with that spacing.

Test Plan:
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2.
- Reset: hold rst_n=0 for several clocks -> anode_out=1111, seg_out=1111111, dp_out=1, frame_tick=0, digit_idx=0.
- Scan: enable=1, digits=16'h1234, dp_mask=0 -> frame_tick every 32 cycles.
  - slot0: 2 blank cycles, then 6 cycles of anode 1110 / seg 0011001.
  - slot1: anode 1101 / seg 0110000.
  - slot2: anode 1011 / seg 0100100.
  - slot3: anode 0111 / seg 1111001.
- Tear-free update: change digits to 16'h5678 during slot1 -> slots 2 and 3 still show 2 and 1; the next frame shows 8,7,6,5 after frame_tick.
- Leading zeros, part 1: digits=16'h0050, dp_mask=0 -> slot0 seg 1000000, slot1 seg 0010010, slots 2 and 3 anode 1111 throughout.
- Leading zeros, part 2: same digits with dp_mask=4'b0100 -> slot2 shows 0 with dp_out=0, slot3 still blank.
- Invalid BCD: digits=16'h000C -> slot0 seg 0111111.
- Enable and reset interaction:
  - Drop enable during slot2 -> next edge anode 1111, digit_idx=0, held.
  - Re-raise enable -> frame_tick on the first edge, then slot0 restarts.
  - Pulse rst_n low mid-slot -> anode_out=1111 before the next clk edge.
